// File: rtl/commit_arbiter.sv
// commit_arbiter: burst-weighted round-robin arbiter feeding the single ROB write port.
// Define COMMIT_ARBITER_STATS_EN to add commit/conflict statistics counters.
`default_nettype none

module commit_arbiter #(
  parameter int NUM_CH = 3,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int BURST  = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          flush_i,
  input  logic [NUM_CH-1:0]             channel_valid_i,
  input  logic [NUM_CH-1:0][TAG_W-1:0]  channel_tag_i,
  input  logic [NUM_CH-1:0][DATA_W-1:0] channel_data_i,
  output logic [NUM_CH-1:0]             channel_ready_o,
  input  logic                          rob_ready_i,
  output logic                          rob_write_o,
  output logic [TAG_W-1:0]              rob_tag_o,
  output logic [DATA_W-1:0]             rob_entry_o,
  output logic [$clog2(NUM_CH)-1:0]     rob_channel_o
`ifdef COMMIT_ARBITER_STATS_EN
  ,
  output logic [31:0]                   commit_count_o,
  output logic [31:0]                   conflict_count_o
`endif
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(BURST + 1);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST);

  logic [CH_W-1:0]  cur;
  logic [CNT_W-1:0] burst_cnt;
  logic             slot_free;
  logic             hold;
  logic             grant_en;
  logic             handshake;
  logic [CH_W-1:0]  scan_idx;
  logic [CH_W-1:0]  search_idx;
  logic [CH_W-1:0]  grant_idx;

  assign slot_free = !rob_write_o || rob_ready_i;
  assign hold      = channel_valid_i[cur] && (burst_cnt < BURST_MAX);
  assign grant_idx = hold ? cur : search_idx;
  assign grant_en  = rst_n_i && slot_free && !flush_i && (|channel_valid_i);
  assign handshake = |(channel_valid_i & channel_ready_o);

  // Scan from the farthest offset down so the nearest valid channel after cur wins; cur itself is last.
  always_comb begin
    search_idx = cur;
    scan_idx   = cur;
    for (int i = NUM_CH; i >= 1; i--) begin
      scan_idx = CH_W'((int'(cur) + i) % NUM_CH);
      if (channel_valid_i[scan_idx]) search_idx = scan_idx;
    end
  end

  always_comb begin
    channel_ready_o = '0;
    if (grant_en) channel_ready_o[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rob_write_o   <= 1'b0;
      rob_tag_o     <= '0;
      rob_entry_o   <= '0;
      rob_channel_o <= '0;
      cur           <= LAST_CH;
      burst_cnt     <= BURST_MAX;
    end else if (flush_i) begin
      rob_write_o   <= 1'b0;
      cur           <= LAST_CH;
      burst_cnt     <= BURST_MAX;
    end else if (handshake) begin
      rob_write_o   <= 1'b1;
      rob_tag_o     <= channel_tag_i[grant_idx];
      rob_entry_o   <= channel_data_i[grant_idx];
      rob_channel_o <= grant_idx;
      if (hold) begin
        burst_cnt <= burst_cnt + CNT_W'(1);
      end else begin
        cur       <= grant_idx;
        burst_cnt <= CNT_W'(1);
      end
    end else if (rob_ready_i) begin
      rob_write_o <= 1'b0;
    end
  end

`ifdef COMMIT_ARBITER_STATS_EN
  logic conflict;
  assign conflict = handshake && (|(channel_valid_i & ~channel_ready_o));

  // Statistics survive flush; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      commit_count_o   <= '0;
      conflict_count_o <= '0;
    end else begin
      if (rob_write_o && rob_ready_i) commit_count_o <= commit_count_o + 32'd1;
      if (conflict) conflict_count_o <= conflict_count_o + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_commit_arbiter.sv
// Self-checking bench for commit_arbiter: directed scenarios plus randomized traffic against a reference model.
`default_nettype none

module tb_commit_arbiter;
  localparam int NUM_CH = 3;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;
  localparam int BURST  = 2;
  localparam int CH_W   = $clog2(NUM_CH);

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          flush;
  logic [NUM_CH-1:0]             valid;
  logic [NUM_CH-1:0][TAG_W-1:0]  tags;
  logic [NUM_CH-1:0][DATA_W-1:0] data;
  logic [NUM_CH-1:0]             ready;
  logic                          rob_ready;
  logic                          rob_write;
  logic [TAG_W-1:0]              rob_tag;
  logic [DATA_W-1:0]             rob_entry;
  logic [CH_W-1:0]               rob_channel;
`ifdef COMMIT_ARBITER_STATS_EN
  logic [31:0]                   commit_count;
  logic [31:0]                   conflict_count;
`endif

  commit_arbiter #(.NUM_CH(NUM_CH), .TAG_W(TAG_W), .DATA_W(DATA_W), .BURST(BURST)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .channel_valid_i(valid), .channel_tag_i(tags), .channel_data_i(data),
    .channel_ready_o(ready), .rob_ready_i(rob_ready),
    .rob_write_o(rob_write), .rob_tag_o(rob_tag), .rob_entry_o(rob_entry),
    .rob_channel_o(rob_channel)
`ifdef COMMIT_ARBITER_STATS_EN
    , .commit_count_o(commit_count), .conflict_count_o(conflict_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: the output slot plus the arbitration pointer and burst count.
  bit                m_wr;
  logic [TAG_W-1:0]  m_tag;
  logic [DATA_W-1:0] m_data;
  int                m_ch, m_cur, m_cnt;
  int                m_commits, m_conflicts;

  function automatic int model_grant();
    if (!rst_n || flush || (m_wr && !rob_ready) || valid == '0) return -1;
    if (valid[m_cur] && m_cnt < BURST) return m_cur;
    for (int i = 1; i <= NUM_CH; i++)
      if (valid[(m_cur + i) % NUM_CH]) return (m_cur + i) % NUM_CH;
    return -1;
  endfunction

  task automatic model_clock();
    int g;
    logic [NUM_CH-1:0] others;
    g = model_grant();
    others = valid;
    if (g >= 0) others[g] = 1'b0;
    if (!rst_n) begin
      m_wr = 0; m_tag = '0; m_data = '0; m_ch = 0; m_cur = NUM_CH - 1; m_cnt = BURST;
      m_commits = 0; m_conflicts = 0;
    end else begin
      if (m_wr && rob_ready) m_commits++;
      if (g >= 0 && others != '0) m_conflicts++;
      if (flush) begin
        m_wr = 0; m_cur = NUM_CH - 1; m_cnt = BURST;
      end else if (g >= 0) begin
        m_wr = 1; m_tag = tags[g]; m_data = data[g]; m_ch = g;
        if (g == m_cur && m_cnt < BURST) m_cnt++;
        else begin m_cur = g; m_cnt = 1; end
      end else if (rob_ready) begin
        m_wr = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; flush = 0; valid = '0; rob_ready = 1;
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; flush = 0; valid = '1; rob_ready = 1;
    for (int k = 0; k < NUM_CH; k++) begin tags[k] = TAG_W'($urandom); data[k] = $urandom; end
    #4;
    n_checks++; if (ready !== '0) $display("FAIL reset_ready: got %b expected 0", ready); else n_pass++;
    tick(); tick();
    n_checks++; if (rob_write !== 1'b0) $display("FAIL reset_write: got %b expected 0", rob_write); else n_pass++;
    n_checks++; if (rob_tag !== '0) $display("FAIL reset_tag: got %h expected 0", rob_tag); else n_pass++;
    n_checks++; if (rob_entry !== '0) $display("FAIL reset_entry: got %h expected 0", rob_entry); else n_pass++;
    n_checks++; if (rob_channel !== '0) $display("FAIL reset_channel: got %0d expected 0", rob_channel); else n_pass++;
    rst_n = 1;
    #3;
    n_checks++; if (ready !== 3'b001) $display("FAIL reset_first_grant: got %b expected 001", ready); else n_pass++;
    tick();
  endtask

  task automatic test_round_robin();
    int order[8] = '{0, 0, 1, 1, 2, 2, 0, 0};
    int cnt[NUM_CH];
    logic [NUM_CH-1:0] expv;
    logic [TAG_W-1:0] prev_tag;
    do_reset();
    valid = '1; rob_ready = 1;
    for (int k = 0; k < NUM_CH; k++) cnt[k] = 0;
    prev_tag = '0;
    for (int i = 0; i <= 8; i++) begin
      for (int k = 0; k < NUM_CH; k++) begin tags[k] = TAG_W'(k * 16 + cnt[k]); data[k] = $urandom; end
      #4;
      if (i < 8) begin
        expv = '0; expv[order[i]] = 1'b1;
        n_checks++; if (ready !== expv) $display("FAIL rr_ready[%0d]: got %b expected %b", i, ready, expv); else n_pass++;
      end
      if (i > 0) begin
        n_checks++; if (rob_write !== 1'b1) $display("FAIL rr_write[%0d]: got %b expected 1", i, rob_write); else n_pass++;
        n_checks++; if (rob_channel !== CH_W'(order[i-1])) $display("FAIL rr_channel[%0d]: got %0d expected %0d", i, rob_channel, order[i-1]); else n_pass++;
        n_checks++; if (rob_tag !== prev_tag) $display("FAIL rr_tag[%0d]: got %h expected %h", i, rob_tag, prev_tag); else n_pass++;
      end else begin
        n_checks++; if (rob_write !== 1'b0) $display("FAIL rr_write_idle: got %b expected 0", rob_write); else n_pass++;
      end
      if (i < 8) begin prev_tag = tags[order[i]]; cnt[order[i]]++; end
      tick();
    end
  endtask

  task automatic test_single_channel();
    do_reset();
    valid = 3'b010; rob_ready = 1;
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) tags[1] = TAG_W'(8'h10 + i); else valid = '0;
      #4;
      if (i < 5) begin
        n_checks++; if (ready !== 3'b010) $display("FAIL single_ready[%0d]: got %b expected 010", i, ready); else n_pass++;
      end
      if (i > 0) begin
        n_checks++; if (rob_write !== 1'b1) $display("FAIL single_write[%0d]: got %b expected 1", i, rob_write); else n_pass++;
        n_checks++; if (rob_tag !== TAG_W'(8'h10 + i - 1)) $display("FAIL single_tag[%0d]: got %h expected %h", i, rob_tag, 8'h10 + i - 1); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    valid = '1; rob_ready = 1;
    for (int k = 0; k < NUM_CH; k++) tags[k] = 6'h05;
    #4;
    n_checks++; if (ready !== 3'b001) $display("FAIL bp_load_ready: got %b expected 001", ready); else n_pass++;
    tick();
    rob_ready = 0;
    tags[0] = 6'h2A; tags[1] = 6'h2B; tags[2] = 6'h2C;
    for (int i = 0; i < 3; i++) begin
      #4;
      n_checks++; if (ready !== '0) $display("FAIL bp_ready[%0d]: got %b expected 0", i, ready); else n_pass++;
      n_checks++; if (rob_tag !== 6'h05) $display("FAIL bp_tag[%0d]: got %h expected 05", i, rob_tag); else n_pass++;
      n_checks++; if (rob_write !== 1'b1) $display("FAIL bp_write[%0d]: got %b expected 1", i, rob_write); else n_pass++;
      tick();
    end
    rob_ready = 1;
    #4;
    n_checks++; if (ready !== 3'b001) $display("FAIL bp_release_ready: got %b expected 001", ready); else n_pass++;
    tick();
    n_checks++; if (rob_tag !== 6'h2A) $display("FAIL bp_next_tag: got %h expected 2a", rob_tag); else n_pass++;
    n_checks++; if (rob_write !== 1'b1) $display("FAIL bp_next_write: got %b expected 1", rob_write); else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    valid = '1; rob_ready = 1;
    tick(); tick(); tick();
    flush = 1;
    #4;
    n_checks++; if (ready !== '0) $display("FAIL flush_ready: got %b expected 0", ready); else n_pass++;
    tick();
    flush = 0;
    #3;
    n_checks++; if (rob_write !== 1'b0) $display("FAIL flush_write: got %b expected 0", rob_write); else n_pass++;
    n_checks++; if (ready !== 3'b001) $display("FAIL flush_regrant: got %b expected 001", ready); else n_pass++;
    tick();
    n_checks++; if (rob_channel !== '0 || rob_write !== 1'b1) $display("FAIL flush_next_write: got ch %0d wr %b expected ch 0 wr 1", rob_channel, rob_write); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [TAG_W-1:0] t0;
    do_reset();
    valid = '1; rob_ready = 1;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < NUM_CH; k++) begin tags[k] = TAG_W'($urandom_range(1, 63)); data[k] = $urandom | 32'h1; end
      tick();
    end
    rst_n = 0;
    #4;
    n_checks++; if (ready !== '0) $display("FAIL rstmid_ready: got %b expected 0", ready); else n_pass++;
    tick();
    rst_n = 1;
    #3;
    n_checks++; if (rob_write !== 1'b0) $display("FAIL rstmid_write: got %b expected 0", rob_write); else n_pass++;
    n_checks++; if (rob_tag !== '0 || rob_entry !== '0 || rob_channel !== '0) $display("FAIL rstmid_slot: got %h/%h/%0d expected 0/0/0", rob_tag, rob_entry, rob_channel); else n_pass++;
    n_checks++; if (ready !== 3'b001) $display("FAIL rstmid_regrant: got %b expected 001", ready); else n_pass++;
    t0 = tags[0];
    tick();
    n_checks++; if (rob_tag !== t0 || rob_channel !== '0) $display("FAIL rstmid_next: got tag %h ch %0d expected tag %h ch 0", rob_tag, rob_channel, t0); else n_pass++;
  endtask

  task automatic test_random();
    int g;
    int wait_cnt[NUM_CH];
    logic [NUM_CH-1:0] expv;
    do_reset();
    for (int k = 0; k < NUM_CH; k++) wait_cnt[k] = 0;
    valid = '1;
    for (int c = 0; c < 800; c++) begin
      rst_n     = ($urandom_range(0, 149) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      rob_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NUM_CH; k++) begin
        if ($urandom_range(0, 9) == 0) valid[k] = ~valid[k];
        tags[k] = TAG_W'($urandom); data[k] = $urandom;
      end
      #4;
      g = model_grant();
      expv = '0;
      if (g >= 0) expv[g] = 1'b1;
      n_checks++; if (ready !== expv) $display("FAIL rand_ready[%0d]: got %b expected %b", c, ready, expv); else n_pass++;
      n_checks++; if (rob_write !== m_wr) $display("FAIL rand_write[%0d]: got %b expected %b", c, rob_write, m_wr); else n_pass++;
      if (m_wr) begin
        n_checks++;
        if (rob_tag !== m_tag || rob_entry !== m_data || rob_channel !== CH_W'(m_ch))
          $display("FAIL rand_slot[%0d]: got %h/%h/%0d expected %h/%h/%0d", c, rob_tag, rob_entry, rob_channel, m_tag, m_data, m_ch);
        else n_pass++;
      end
      // Fairness: handshakes seen while a channel stays valid and ungranted.
      if (!rst_n || flush) begin
        for (int k = 0; k < NUM_CH; k++) wait_cnt[k] = 0;
      end else if (|(valid & ready)) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (valid[k] && !ready[k]) begin
            wait_cnt[k]++;
            n_checks++;
            if (wait_cnt[k] > (NUM_CH - 1) * BURST) $display("FAIL rand_fair[%0d] ch%0d: waited %0d, limit %0d", c, k, wait_cnt[k], (NUM_CH - 1) * BURST);
            else n_pass++;
          end else wait_cnt[k] = 0;
        end
      end else begin
        for (int k = 0; k < NUM_CH; k++) if (!valid[k]) wait_cnt[k] = 0;
      end
      tick();
    end
    rst_n = 1; flush = 0;
`ifdef COMMIT_ARBITER_STATS_EN
    n_checks++; if (commit_count !== 32'(m_commits)) $display("FAIL rand_commits: got %0d expected %0d", commit_count, m_commits); else n_pass++;
    n_checks++; if (conflict_count !== 32'(m_conflicts)) $display("FAIL rand_conflicts: got %0d expected %0d", conflict_count, m_conflicts); else n_pass++;
`endif
  endtask

`ifdef COMMIT_ARBITER_STATS_EN
  task automatic test_stats();
    do_reset();
    valid = '1; rob_ready = 1;
    for (int i = 0; i < 8; i++) tick();
    valid = '0;
    tick();
    n_checks++; if (commit_count !== 32'd8) $display("FAIL stats_commit: got %0d expected 8", commit_count); else n_pass++;
    n_checks++; if (conflict_count !== 32'd8) $display("FAIL stats_conflict: got %0d expected 8", conflict_count); else n_pass++;
    flush = 1;
    tick();
    flush = 0;
    tick();
    n_checks++; if (commit_count !== 32'd8 || conflict_count !== 32'd8) $display("FAIL stats_flush: got %0d/%0d expected 8/8", commit_count, conflict_count); else n_pass++;
  endtask
`endif

  initial begin
    rst_n = 0; flush = 0; valid = '0; rob_ready = 0; tags = '0; data = '0;
    test_reset();
    test_round_robin();
    test_single_channel();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
`ifdef COMMIT_ARBITER_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/commit_arbiter.md
Name: commit_arbiter

Overview:
Sequences the single reorder-buffer write port between NUM_CH commit channels (ITU/CSR-reduced buffer, LSU buffer, future units). Uses burst-weighted round-robin with a valid/ready handshake per channel. Has a registered output slot that honours ROB backpressure, and supports pipeline flush. Sits between the per-unit commit buffers and the ROB in the back end.

Parameters:
NUM_CH, 3, number of requesting commit channels (2..8)
TAG_W, 6, ROB tag width
DATA_W, 32, ROB entry payload width
BURST, 2, max consecutive handshakes one channel keeps the grant while others wait (>=1)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset
flush_i  in  1  pipeline flush
channel_valid_i  in  NUM_CH  channel k holds a valid entry
channel_tag_i  in  NUM_CH x TAG_W  per-channel ROB tag
channel_data_i  in  NUM_CH x DATA_W  per-channel ROB entry
channel_ready_o  out  NUM_CH  handshake accept, one-hot0
rob_ready_i  in  1  ROB accepts current write this cycle
rob_write_o  out  1  output slot valid
rob_tag_o  out  TAG_W  tag of slot
rob_entry_o  out  DATA_W  entry of slot
rob_channel_o  out  $clog2(NUM_CH)  source channel of slot

Behaviour:
- Single clock clk_i; reset rst_n_i synchronous, active-low, sampled on posedge clk_i only.
- Reset values: rob_write_o=0, rob_tag_o=0, rob_entry_o=0, rob_channel_o=0, cur=NUM_CH-1, burst_cnt=BURST. channel_ready_o is combinational; it is 0 while rst_n_i=0.
- slot_free = !rob_write_o | rob_ready_i.
- Handshake on channel k: channel_valid_i[k] & channel_ready_o[k].
- channel_ready_o is non-zero only when slot_free & !flush_i & any valid. Exactly one bit is set: the granted channel.
- Grant selection (combinational):
  - Hold path: valid[cur] & burst_cnt<BURST -> grant cur.
  - Search path: otherwise, first valid channel scanning cur+1, cur+2, ... wrapping modulo NUM_CH, with cur checked last.
- State update, on handshake only:
  - Hold path: burst_cnt<=burst_cnt+1.
  - Search path: cur<=granted, burst_cnt<=1.
  - No handshake: cur and burst_cnt unchanged.
- Output slot:
  - Handshake: slot loads tag/data/channel of the granted channel, rob_write_o<=1. Latency is exactly 1 cycle from handshake to rob_write_o.
  - No handshake but rob_ready_i & rob_write_o: rob_write_o<=0.
  - rob_write_o & !rob_ready_i: slot contents held stable and all ready=0.
  - Drain and refill in the same cycle is allowed, giving back-to-back writes at 1 per cycle.
- Fairness: a continuously valid channel waits at most (NUM_CH-1)*BURST handshakes.
- Flush: in the cycle flush_i=1, ready=0. Next cycle rob_write_o=0, cur=NUM_CH-1, burst_cnt=BURST, so arbitration restarts at channel 0. Flush overrides rob_ready_i and any pending handshake.
- Reset mid-operation: identical to flush. The in-flight slot is dropped.
- Payload on unselected channels is don't-care. Data is never modified; widths are passed through.

Optional Feature:
COMMIT_ARBITER_STATS_EN:
- When defined: adds outputs commit_count_o (32) and conflict_count_o (32).
  - commit_count_o increments on each ROB write accepted (rob_write_o & rob_ready_i).
  - conflict_count_o increments each cycle in which a handshake occurs while at least one other channel is valid and not granted.
  - Both counters wrap at 2^32, are cleared by reset, and are not cleared by flush.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. Defaults, after reset, channels 0,1,2 valid continuously, tags 0x00..0x3F increasing per channel, rob_ready_i=1 -> handshake order 0,0,1,1,2,2,0,0. rob_write_o=1 from the cycle after the first handshake, one write every cycle, rob_channel_o matching the order.
2. Only channel 1 valid for 5 cycles, tags 0x10..0x14 -> granted every cycle (search path returns cur). rob_tag_o=0x10..0x14 on 5 consecutive cycles, no bubbles.
3. Slot holds tag 0x05, rob_ready_i=0 for 3 cycles, all channels valid -> rob_tag_o stays 0x05 and channel_ready_o=0 for those 3 cycles. On release, a handshake occurs in the same cycle and the next write appears 1 cycle later.
4. Mid-burst (cur=1, burst_cnt=1) with rob_write_o=1, assert flush_i for 1 cycle -> ready=0 in the flush cycle, rob_write_o=0 next cycle, next grant goes to channel 0 with all valid.
5. rst_n_i=0 for 1 cycle during traffic -> all outputs at reset values next cycle, arbitration restarts at channel 0, no stale tag written.
6. With COMMIT_ARBITER_STATS_EN, scenario 1 for 8 accepted writes -> commit_count_o=8, conflict_count_o=8. A following flush leaves both values unchanged.
